// File: rtl/fir_share_sequencer_if.sv
// Handshake bundle between the pin mapping, the shared FIR and the sequencer.
// slave  : sequencer side.
// master : environment side (requesters, FIR instance, result consumer).
// fir_err exists only when FIR_SHARE_TIMEOUT_EN is defined.
interface fir_share_sequencer_if #(
  parameter int DATA_W = 6,
  parameter int OUT_W  = 8
);
  logic [DATA_W-1:0] ch0_tdata;
  logic              ch0_tvalid;
  logic              ch0_tready;
  logic [DATA_W-1:0] ch1_tdata;
  logic              ch1_tvalid;
  logic              ch1_tready;
  logic [DATA_W-1:0] fir_tdata;
  logic              fir_tvalid;
  logic              fir_tready;
  logic [OUT_W-1:0]  fir_rdata;
  logic [OUT_W-1:0]  res_tdata;
  logic              res_tchan;
  logic              res_tvalid;
  logic              res_tready;
  logic              busy;
`ifdef FIR_SHARE_TIMEOUT_EN
  logic              fir_err;
`endif

  modport slave (
    input  ch0_tdata, ch0_tvalid, output ch0_tready,
    input  ch1_tdata, ch1_tvalid, output ch1_tready,
    output fir_tdata, fir_tvalid, input fir_tready, fir_rdata,
    output res_tdata, res_tchan, res_tvalid, input res_tready,
    output busy
`ifdef FIR_SHARE_TIMEOUT_EN
    , output fir_err
`endif
  );

  modport master (
    output ch0_tdata, ch0_tvalid, input ch0_tready,
    output ch1_tdata, ch1_tvalid, input ch1_tready,
    input  fir_tdata, fir_tvalid, output fir_tready, fir_rdata,
    input  res_tdata, res_tchan, res_tvalid, output res_tready,
    input  busy
`ifdef FIR_SHARE_TIMEOUT_EN
    , input fir_err
`endif
  );
endinterface

// File: rtl/fir_share_sequencer.sv
// Time-shares one FIR between two requesters with round-robin arbitration.
// One sample is in flight at a time: accept -> issue to FIR -> wait the fixed
// pipeline latency -> capture and hold the tagged result until taken.
// Optional build macro FIR_SHARE_TIMEOUT_EN adds an issue watchdog and a
// sticky fir_err flag.
//
// state  | meaning
// IDLE   | arbitrate, accept one sample from ch0 or ch1
// ISSUE  | sample presented to the FIR, waiting for fir_tready
// WAIT   | counting down the FIR pipeline latency
// OUTPUT | result held on res_* until res_tready
module fir_share_sequencer #(
  parameter int DATA_W      = 6,
  parameter int OUT_W       = 8,
  parameter int FIR_LATENCY = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_share_sequencer_if.slave   bus
);

  // Reject parameter sets the latency counter or watchdog cannot represent.
  if (FIR_LATENCY < 1 || (2 ** CNT_W) <= FIR_LATENCY || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fir_share_sequencer: illegal FIR_LATENCY/CNT_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_chan;
  logic [DATA_W-1:0] r_sample;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fir_tvalid;
  logic [OUT_W-1:0]  r_res_tdata;
  logic              r_res_tchan;
  logic              r_res_tvalid;

  logic              w_grant;
  logic              w_accept;
  logic              w_ch0_tready;
  logic              w_ch1_tready;
  logic              w_timeout;

  // ch1 wins only when ch0 is idle or ch0 had the previous grant.
  assign w_grant = bus.ch1_tvalid & (~bus.ch0_tvalid | ~r_last_grant);

`ifdef FIR_SHARE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_fir_err;

  // Last stalled ISSUE cycle before the watchdog limit drops the sample.
  assign w_timeout = (r_state == ISSUE) & ~bus.fir_tready &
                     (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counts stalled ISSUE cycles; fir_err is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd      <= '0;
      r_fir_err <= 1'b0;
    end else begin
      if (w_accept)
        r_wd <= '0;
      else if (r_state == ISSUE && !bus.fir_tready)
        r_wd <= r_wd + 1'b1;
      if (w_timeout)
        r_fir_err <= 1'b1;
    end
  end

  assign bus.fir_err = r_fir_err;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and combinational accept strobes.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_ch0_tready = 1'b0;
    w_ch1_tready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ch0_tready = bus.ch0_tvalid & ~w_grant;
        w_ch1_tready = w_grant;
        if (bus.ch0_tvalid || bus.ch1_tvalid) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.fir_tready) w_next = WAIT;
        else if (w_timeout) w_next = IDLE;
      end
      WAIT: begin
        if (r_cnt == '0) w_next = OUTPUT;
      end
      OUTPUT: begin
        if (bus.res_tready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: sample capture, FIR issue, latency countdown, result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_chan       <= 1'b0;
      r_sample     <= '0;
      r_cnt        <= '0;
      r_fir_tvalid <= 1'b0;
      r_res_tdata  <= '0;
      r_res_tchan  <= 1'b0;
      r_res_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sample     <= w_grant ? bus.ch1_tdata : bus.ch0_tdata;
            r_chan       <= w_grant;
            r_last_grant <= w_grant;
            r_fir_tvalid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.fir_tready) begin
            r_fir_tvalid <= 1'b0;
            r_cnt        <= CNT_W'(FIR_LATENCY - 1);
          end else if (w_timeout) begin
            r_fir_tvalid <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_res_tdata  <= bus.fir_rdata;
            r_res_tchan  <= r_chan;
            r_res_tvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.res_tready) r_res_tvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ch0_tready = w_ch0_tready;
  assign bus.ch1_tready = w_ch1_tready;
  assign bus.fir_tdata  = r_sample;
  assign bus.fir_tvalid = r_fir_tvalid;
  assign bus.res_tdata  = r_res_tdata;
  assign bus.res_tchan  = r_res_tchan;
  assign bus.res_tvalid = r_res_tvalid;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fir_share_sequencer.sv
// Directed bench for fir_share_sequencer with hand-computed expectations.
module tb_fir_share_sequencer;
  localparam int LAT = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  fir_share_sequencer_if #(.DATA_W(6), .OUT_W(8)) bus ();

  fir_share_sequencer #(
    .DATA_W(6), .OUT_W(8), .FIR_LATENCY(LAT), .CNT_W(3), .TIMEOUT_CYC(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the FIR handshake; drives a decoy on
  // fir_rdata except in the capture cycle and checks the exact latency.
  task automatic expect_result(input logic [7:0] cap, input logic chan);
    for (int k = 1; k <= LAT; k++) begin
      bus.fir_rdata = (k == LAT) ? cap : ~cap;
      chk("res_tvalid_early", 32'(bus.res_tvalid), 32'd0);
      step();
    end
    bus.fir_rdata = 8'h00;
    chk("res_tvalid", 32'(bus.res_tvalid), 32'd1);
    chk("res_tdata",  32'(bus.res_tdata),  32'(cap));
    chk("res_tchan",  32'(bus.res_tchan),  32'(chan));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.ch0_tdata  = '0;
    bus.ch0_tvalid = 1'b0;
    bus.ch1_tdata  = '0;
    bus.ch1_tvalid = 1'b0;
    bus.fir_tready = 1'b0;
    bus.fir_rdata  = '0;
    bus.res_tready = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_fir_tvalid", 32'(bus.fir_tvalid), 32'd0);
    chk("rst_fir_tdata",  32'(bus.fir_tdata),  32'd0);
    chk("rst_res_tvalid", 32'(bus.res_tvalid), 32'd0);
    chk("rst_res_tdata",  32'(bus.res_tdata),  32'd0);
    chk("rst_res_tchan",  32'(bus.res_tchan),  32'd0);
    chk("rst_ch0_tready", 32'(bus.ch0_tready), 32'd0);
    reset = 1'b0;
    #1;

    // Single ch0 sample.
    bus.ch0_tvalid = 1'b1;
    bus.ch0_tdata  = 6'h15;
    bus.fir_tready = 1'b1;
    bus.res_tready = 1'b1;
    #1;
    chk("t1_ch0_tready", 32'(bus.ch0_tready), 32'd1);
    chk("t1_ch1_tready", 32'(bus.ch1_tready), 32'd0);
    step();
    bus.ch0_tvalid = 1'b0;
    #1;
    chk("t1_ch0_tready_off", 32'(bus.ch0_tready), 32'd0);
    chk("t1_fir_tvalid",     32'(bus.fir_tvalid), 32'd1);
    chk("t1_fir_tdata",      32'(bus.fir_tdata),  32'h15);
    chk("t1_busy",           32'(bus.busy),       32'd1);
    step();
    chk("t1_fir_tvalid_off", 32'(bus.fir_tvalid), 32'd0);
    expect_result(8'hA5, 1'b0);
    step();
    chk("t1_idle_busy",  32'(bus.busy),       32'd0);
    chk("t1_res_clear",  32'(bus.res_tvalid), 32'd0);

    // Both channels continuously valid: strict alternation from ch0.
    do_reset();
    bus.ch0_tvalid = 1'b1;
    bus.ch0_tdata  = 6'h01;
    bus.ch1_tvalid = 1'b1;
    bus.ch1_tdata  = 6'h02;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_ch0_tready", 32'(bus.ch0_tready), 32'((i % 2) == 0));
      chk("rr_ch1_tready", 32'(bus.ch1_tready), 32'((i % 2) == 1));
      step();
      chk("rr_fir_tdata", 32'(bus.fir_tdata), ((i % 2) == 0) ? 32'h01 : 32'h02);
      step();
      expect_result(8'h10 + 8'(i), 1'(i % 2));
      step();
      chk("rr_idle", 32'(bus.busy), 32'd0);
    end
    bus.ch0_tvalid = 1'b0;
    bus.ch1_tvalid = 1'b0;
    #1;
    chk("rr_no_valid_tready", 32'({bus.ch0_tready, bus.ch1_tready}), 32'd0);

    // FIR stalls for 5 cycles in ISSUE.
    bus.ch1_tvalid = 1'b1;
    bus.ch1_tdata  = 6'h2A;
    #1;
    chk("st_ch1_tready", 32'(bus.ch1_tready), 32'd1);
    step();
    bus.ch1_tvalid = 1'b0;
    bus.fir_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("st_fir_tvalid", 32'(bus.fir_tvalid), 32'd1);
      chk("st_fir_tdata",  32'(bus.fir_tdata),  32'h2A);
      step();
    end
    bus.fir_tready = 1'b1;
    step();
    expect_result(8'h77, 1'b1);

    // Consumer back-pressure in OUTPUT; ch0 waits for the return to IDLE.
    bus.res_tready = 1'b0;
    bus.ch0_tvalid = 1'b1;
    bus.ch0_tdata  = 6'h05;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_res_tvalid", 32'(bus.res_tvalid), 32'd1);
      chk("bp_res_tdata",  32'(bus.res_tdata),  32'h77);
      chk("bp_res_tchan",  32'(bus.res_tchan),  32'd1);
      chk("bp_treadys",    32'({bus.ch0_tready, bus.ch1_tready}), 32'd0);
      chk("bp_busy",       32'(bus.busy),       32'd1);
      step();
    end
    bus.res_tready = 1'b1;
    #1;
    chk("bp_ch0_tready_out", 32'(bus.ch0_tready), 32'd0);
    step();
    chk("bp_res_clear",      32'(bus.res_tvalid), 32'd0);
    chk("bp_ch0_tready_idle", 32'(bus.ch0_tready), 32'd1);
    step();
    bus.ch0_tvalid = 1'b0;
    chk("bp_fir_tdata", 32'(bus.fir_tdata), 32'h05);
    step();
    step();

    // Reset in WAIT drops the sample; ch0 gets the next grant.
    chk("rw_busy_wait", 32'(bus.busy), 32'd1);
    bus.ch0_tvalid = 1'b1;
    bus.ch0_tdata  = 6'h33;
    bus.ch1_tvalid = 1'b1;
    bus.ch1_tdata  = 6'h0C;
    reset = 1'b1;
    #1;
    chk("rw_busy",       32'(bus.busy),       32'd0);
    chk("rw_fir_tvalid", 32'(bus.fir_tvalid), 32'd0);
    chk("rw_fir_tdata",  32'(bus.fir_tdata),  32'd0);
    chk("rw_res_tvalid", 32'(bus.res_tvalid), 32'd0);
    chk("rw_res_tdata",  32'(bus.res_tdata),  32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rw_ch0_tready", 32'(bus.ch0_tready), 32'd1);
    chk("rw_ch1_tready", 32'(bus.ch1_tready), 32'd0);
    step();
    bus.ch0_tvalid = 1'b0;
    bus.ch1_tvalid = 1'b0;
    chk("rw_fir_tdata_next", 32'(bus.fir_tdata), 32'h33);
    step();
    expect_result(8'h5A, 1'b0);
    step();

`ifdef FIR_SHARE_TIMEOUT_EN
    // Watchdog: FIR never ready, sample dropped after 15 stalled cycles.
    do_reset();
    chk("to_err_rst", 32'(bus.fir_err), 32'd0);
    bus.ch0_tvalid = 1'b1;
    bus.ch0_tdata  = 6'h11;
    bus.fir_tready = 1'b0;
    step();
    bus.ch0_tvalid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("to_fir_tvalid", 32'(bus.fir_tvalid), 32'd1);
      chk("to_err_low",    32'(bus.fir_err),    32'd0);
      step();
    end
    chk("to_fir_tvalid_drop", 32'(bus.fir_tvalid), 32'd0);
    chk("to_err_set",         32'(bus.fir_err),    32'd1);
    chk("to_busy",            32'(bus.busy),       32'd0);
    chk("to_res_tvalid",      32'(bus.res_tvalid), 32'd0);
    bus.ch1_tvalid = 1'b1;
    bus.ch1_tdata  = 6'h22;
    bus.fir_tready = 1'b1;
    #1;
    chk("to_ch1_tready", 32'(bus.ch1_tready), 32'd1);
    step();
    bus.ch1_tvalid = 1'b0;
    chk("to_fir_tdata", 32'(bus.fir_tdata), 32'h22);
    step();
    expect_result(8'h33, 1'b1);
    chk("to_err_sticky", 32'(bus.fir_err), 32'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_share_sequencer.md
Name: fir_share_sequencer

Overview:
- Time-shares one FIR datapath instance between two sample requesters (ch0, ch1).
- Round-robin arbitration picks one sample at a time and issues it to the FIR on a valid/ready handshake.
- Waits a fixed FIR pipeline latency, then captures the FIR output and presents it with a channel tag.
- Sits between the top-level pin mapping and the FIR instance.

Parameters:
- DATA_W, 6: sample width fed to the FIR.
- OUT_W, 8: FIR result width.
- FIR_LATENCY, 4: cycles from FIR input handshake to valid FIR output; must be >= 1.
- CNT_W, 3: latency counter width; must satisfy 2**CNT_W > FIR_LATENCY.
- TIMEOUT_CYC, 15: issue watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch0_tdata  in  DATA_W  sample from requester 0.
- ch0_tvalid  in  1  requester 0 has a sample.
- ch0_tready  out  1  sequencer accepts ch0 sample this cycle.
- ch1_tdata  in  DATA_W  sample from requester 1.
- ch1_tvalid  in  1  requester 1 has a sample.
- ch1_tready  out  1  sequencer accepts ch1 sample this cycle.
- fir_tdata  out  DATA_W  sample to FIR.
- fir_tvalid  out  1  sample on fir_tdata is valid.
- fir_tready  in  1  FIR accepts the sample.
- fir_rdata  in  OUT_W  FIR output data.
- res_tdata  out  OUT_W  captured FIR result.
- res_tchan  out  1  channel that produced res_tdata.
- res_tvalid  out  1  result available.
- res_tready  in  1  consumer takes the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 so ch0 has first priority.
  - sample_reg=0, cnt=0.
  - res_tdata=0, res_tchan=0, res_tvalid=0, fir_tvalid=0, fir_tdata=0.
  - Reset mid-transaction drops the in-flight sample silently.
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - grant = ch1 if ch1_tvalid & (!ch0_tvalid | last_grant==0); else ch0.
  - chX_tready = (state==IDLE) & (grant==X), combinational; at most one is high.
  - On valid&ready: sample_reg<=chX_tdata, chan_reg<=X, last_grant<=X, go ISSUE.
  - With no valid input, stay in IDLE and drive both treadys low.
- ISSUE:
  - fir_tvalid=1, fir_tdata=sample_reg; both are registered outputs of the state.
  - On fir_tready: cnt<=FIR_LATENCY-1, go WAIT.
  - Otherwise hold fir_tdata stable.
- WAIT:
  - If cnt==0: res_tdata<=fir_rdata, res_tchan<=chan_reg, res_tvalid<=1, go OUTPUT.
  - Else cnt<=cnt-1.
  - FIR handshake at the edge ending cycle S means fir_rdata is sampled at the edge ending cycle S+FIR_LATENCY and res_tvalid is high from cycle S+FIR_LATENCY+1.
- OUTPUT:
  - Hold res_* stable until res_tready.
  - On res_tready: res_tvalid<=0, go IDLE.
  - The next sample can be accepted in the cycle after that return at the earliest.
  - Back-to-back throughput = one sample per FIR_LATENCY+3 cycles with no stalls.
- Fairness: with both channels continuously valid, grants strictly alternate.
- fir_rdata is ignored outside the capture cycle.
- There is no arithmetic on the data; widths pass through unchanged.

Optional Feature:
- Macro: FIR_SHARE_TIMEOUT_EN.
- Defined:
  - Adds output port fir_err (1 bit, sticky, reset 0).
  - In ISSUE, a watchdog counts cycles with fir_tvalid&!fir_tready.
  - When the count reaches TIMEOUT_CYC, the sample is dropped, fir_tvalid<=0, fir_err<=1, and state goes IDLE; no result is produced.
  - The watchdog counter clears on entering ISSUE.
  - fir_err clears only on reset.
- Undefined: no fir_err port and no watchdog; ISSUE waits indefinitely.

Test Plan:
- Reset then ch0_tvalid=1 with ch0_tdata=6'h15, fir_tready=1, fir_rdata=8'hA5 at the capture cycle, res_tready=1 -> ch0_tready pulses once; fir_tdata=6'h15; res_tdata=8'hA5, res_tchan=0, valid FIR_LATENCY+1 cycles after the FIR handshake.
- Both channels valid continuously, ch0=6'h01, ch1=6'h02 -> grant order ch0,ch1,ch0,ch1; res_tchan alternates 0,1,0,1.
- fir_tready held low for 5 cycles in ISSUE -> fir_tvalid stays high and fir_tdata stays stable; after fir_tready=1, the result appears FIR_LATENCY+1 cycles later.
- res_tready low for 3 cycles in OUTPUT -> res_tdata/res_tchan stable, both treadys low, busy=1; a new sample is accepted only after res_tready.
- Assert reset during WAIT -> all outputs 0 immediately, state IDLE; next grant goes to ch0 when both channels are valid.
- With FIR_SHARE_TIMEOUT_EN: fir_tready stuck low -> after 15 cycles fir_tvalid=0, fir_err=1, no res_tvalid; the next request is still served.
